// File: rtl/bus_cycle_master.sv
// 8088 minimum-mode bus-cycle master: one REQ becomes a registered T1-T2-T3-(TW*)-T4 cycle, REQ edge to ACK = 3 + wait states.
// No request queue: REQ is only sampled in IDLE, and READY low stretches the cycle through TW up to MAX_WAIT before aborting.
module bus_cycle_master #(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_WAIT   = 15
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  REQ,
   input  logic                  WE,
   input  logic                  IO,
   input  logic [ADDR_WIDTH-1:0] ADDR,
   input  logic [DATA_WIDTH-1:0] WDATA,
   output logic                  ACK,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic                  TIMEOUT,
   output logic                  BUSY,
   output logic                  ALE,
   output logic                  IOM,
   output logic                  RD_n,
   output logic                  WR_n,
   output logic [ADDR_WIDTH-9:0] A,
   inout  wire  [DATA_WIDTH-1:0] AD,
   input  logic                  READY
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_TW   = 3'd4,
      S_T4   = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic                    io_q, io_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    expire;

   logic                    ale_q, ale_d;
   logic                    busy_q, busy_d;
   logic                    ack_q, ack_d;
   logic                    timeout_q, timeout_d;
   logic                    rd_n_q, rd_n_d;
   logic                    wr_n_q, wr_n_d;
   logic                    ad_oe_q, ad_oe_d;
   logic [DATA_WIDTH-1:0]   ad_out_q, ad_out_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         io_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ale_q     <= 1'b0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         timeout_q <= 1'b0;
         rd_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         ad_oe_q   <= 1'b0;
         ad_out_q  <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         io_q      <= io_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ale_q     <= ale_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         timeout_q <= timeout_d;
         rd_n_q    <= rd_n_d;
         wr_n_q    <= wr_n_d;
         ad_oe_q   <= ad_oe_d;
         ad_out_q  <= ad_out_d;
         rdata_q   <= rdata_d;
      end
   end

   // The bound check precedes the increment, so the wait counter never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      io_d    = io_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      expire  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (REQ) begin
               state_d = S_T1;
               we_d    = WE;
               io_d    = IO;
               addr_d  = ADDR;
               wdata_d = WDATA;
            end
         end
         S_T1: state_d = S_T2;
         S_T2: state_d = S_T3;
         S_T3: begin
            if (READY) begin
               state_d = S_T4;
            end else begin
               state_d = S_TW;
               cnt_d   = CNT_W'(1);
            end
         end
         S_TW: begin
            if (READY) begin
               state_d = S_T4;
            end else if (cnt_q == MAX_CNT) begin
               state_d = S_T4;
               expire  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_T4: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every pin comes straight from a flop.
   always_comb begin
      ale_d     = 1'b0;
      busy_d    = (state_d != S_IDLE);
      ack_d     = (state_d == S_T4);
      timeout_d = expire;
      rd_n_d    = 1'b1;
      wr_n_d    = 1'b1;
      ad_oe_d   = 1'b0;
      ad_out_d  = ad_out_q;
      rdata_d   = rdata_q;
      case (state_d)
         S_T1: begin
            ale_d    = 1'b1;
            ad_oe_d  = 1'b1;
            ad_out_d = DATA_WIDTH'(addr_d[7:0]);
         end
         S_T2, S_T3, S_TW: begin
            rd_n_d   = we_d;
            wr_n_d   = ~we_d;
            ad_oe_d  = we_d;
            ad_out_d = wdata_d;
         end
         S_T4: begin
            ad_oe_d  = we_d;
            ad_out_d = wdata_d;
         end
         default: ;
      endcase
      // T4 is only entered from T3 or TW, which is exactly the read-capture edge.
      if (state_d == S_T4 && !we_q) begin
         rdata_d = expire ? {DATA_WIDTH{1'b1}} : AD;
      end
   end

   assign AD      = ad_oe_q ? ad_out_q : {DATA_WIDTH{1'bz}};
   assign ACK     = ack_q;
   assign RDATA   = rdata_q;
   assign TIMEOUT = timeout_q;
   assign BUSY    = busy_q;
   assign ALE     = ale_q;
   assign IOM     = io_q;
   assign RD_n    = rd_n_q;
   assign WR_n    = wr_n_q;
   assign A       = addr_q[ADDR_WIDTH-1:8];

   a_strobe_excl : assert property (@(posedge CLK) disable iff (!RESET) (rd_n_q || wr_n_q));
   a_no_drive_rd : assert property (@(posedge CLK) disable iff (!RESET) !(ad_oe_q && !rd_n_q));

endmodule
